guess_entry: RTL

//  Front end of the lock: collects a WIDTH-bit guess one bit at a time from the user

---
 rtl/guess_entry.sv | 126 ++++++++++++
 1 files changed

// File: rtl/guess_entry.sv
// Guess entry front end for the lock: shifts in a WIDTH-bit guess MSB first,
// pulses done, then drives the unlock window and the wrong-guess lockout.
module guess_entry #(
    parameter int WIDTH          = 5,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 50,
    parameter int OPEN_CYCLES    = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_strobe,
    input  logic             clear,
    input  logic             correct,
    output logic [WIDTH-1:0] guess,
    output logic             done,
    output logic [2:0]       bit_count,
    output logic             unlocked,
    output logic             locked_out,
    output logic [1:0]       fail_count
);
    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES - 1 : LOCKOUT_CYCLES - 1;
    localparam int TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

    localparam logic [2:0]    LAST_BIT   = 3'(WIDTH - 1);
    localparam logic [1:0]    LAST_FAIL  = 2'(MAX_TRIES - 1);
    localparam logic [TW-1:0] OPEN_INIT  = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_INIT  = TW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_ENTRY,
        S_CHECK,
        S_EVAL,
        S_OPEN,
        S_LOCKOUT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [2:0]       bit_count_q, bit_count_d;
    logic [1:0]       fail_count_q, fail_count_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             done_q, done_d;
    logic             unlocked_q, unlocked_d;
    logic             locked_out_q, locked_out_d;

    always_comb begin
        state_d      = state_q;
        guess_d      = guess_q;
        bit_count_d  = bit_count_q;
        fail_count_d = fail_count_q;
        timer_d      = timer_q;
        case (state_q)
            S_ENTRY: begin
                if (clear) begin
                    guess_d     = '0;
                    bit_count_d = '0;
                end else if (bit_strobe) begin
                    guess_d     = {guess_q[WIDTH-2:0], bit_in};
                    bit_count_d = bit_count_q + 3'd1;
                    if (bit_count_q == LAST_BIT) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: state_d = S_EVAL;
            S_EVAL: begin
                guess_d     = '0;
                bit_count_d = '0;
                if (correct) begin
                    state_d      = S_OPEN;
                    fail_count_d = '0;
                    timer_d      = OPEN_INIT;
                end else if (fail_count_q == LAST_FAIL) begin
                    state_d      = S_LOCKOUT;
                    fail_count_d = '0;
                    timer_d      = LOCK_INIT;
                end else begin
                    state_d      = S_ENTRY;
                    fail_count_d = fail_count_q + 2'd1;
                end
            end
            S_OPEN, S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = S_ENTRY;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = S_ENTRY;
        endcase
        // Status flags are registered from the next state so they line up with it.
        done_d       = (state_d == S_CHECK);
        unlocked_d   = (state_d == S_OPEN);
        locked_out_d = (state_d == S_LOCKOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_ENTRY;
            guess_q      <= '0;
            bit_count_q  <= '0;
            fail_count_q <= '0;
            timer_q      <= '0;
            done_q       <= 1'b0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            guess_q      <= guess_d;
            bit_count_q  <= bit_count_d;
            fail_count_q <= fail_count_d;
            timer_q      <= timer_d;
            done_q       <= done_d;
            unlocked_q   <= unlocked_d;
            locked_out_q <= locked_out_d;
        end
    end

    assign guess      = guess_q;
    assign done       = done_q;
    assign bit_count  = bit_count_q;
    assign unlocked   = unlocked_q;
    assign locked_out = locked_out_q;
    assign fail_count = fail_count_q;
endmodule
